// File: rtl/rtc_pkg.sv
// Shared time-of-day field widths, limits and the packed time record used by
// the timekeeper and the display/bus blocks that read it.
package rtc_pkg;

  localparam int SEC_W   = 6;
  localparam int MIN_W   = 6;
  localparam int HR_W    = 5;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;

  typedef struct packed {
    logic [HR_W-1:0]  hr;
    logic [MIN_W-1:0] min;
    logic [SEC_W-1:0] sec;
  } rtc_time_t;

endpackage

// File: rtl/rtc_wrap_counter.sv
// Modulo-(MAX+1) counter with synchronous load; carry_out marks an increment
// that wraps, so instances chain seconds -> minutes -> hours.
module rtc_wrap_counter #(
  parameter int W   = 6,
  parameter int MAX = 59
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] val,
  output logic         carry_out
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic at_max;

  assign at_max    = (val == MAX_V);
  assign carry_out = inc & at_max;

  always_ff @(posedge clk) begin
    if (rst)       val <= '0;
    else if (load) val <= load_val;
    else if (inc)  val <= at_max ? '0 : val + W'(1);
  end

endmodule

// File: rtl/rtc_timekeeper.sv
// Seconds-tick consumer: hh:mm:ss counters fed by sec_clk rising edges, with a
// range-checked load handshake and an hh:mm alarm that only tick updates fire.
module rtc_timekeeper
  import rtc_pkg::*;
#(
  parameter int HOURS_PER_DAY = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sec_clk,
  input  logic             en,
  input  logic             set_valid,
  input  logic [HR_W-1:0]  set_hr,
  input  logic [MIN_W-1:0] set_min,
  input  logic [SEC_W-1:0] set_sec,
  output logic             set_ack,
  output logic             set_err,
  input  logic             alarm_en,
  input  logic [HR_W-1:0]  alarm_hr,
  input  logic [MIN_W-1:0] alarm_min,
  output logic [HR_W-1:0]  hr,
  output logic [MIN_W-1:0] min,
  output logic [SEC_W-1:0] sec,
  output logic             day_pulse,
  output logic             alarm_fire,
  output logic             time_valid
);

  logic      sec_clk_q;
  logic      tick;
  logic      set_legal;
  logic      load;
  logic      cnt;
  logic      sec_carry;
  logic      min_carry;
  logic      hr_carry;
  rtc_time_t set_time;
  logic [MIN_W-1:0] min_nxt;
  logic [HR_W-1:0]  hr_nxt;
  logic             alarm_hit;

  // Resetting the edge register high keeps a level-high sec_clk at reset
  // release from looking like a rising edge.
  always_ff @(posedge clk) begin
    if (rst) sec_clk_q <= 1'b1;
    else     sec_clk_q <= sec_clk;
  end

  assign tick = sec_clk & ~sec_clk_q;

  assign set_time  = '{hr: set_hr, min: set_min, sec: set_sec};
  assign set_legal = ({1'b0, set_hr} < 6'(HOURS_PER_DAY)) &&
                     (set_min <= MIN_W'(MIN_MAX)) &&
                     (set_sec <= SEC_W'(SEC_MAX));
  assign load      = set_valid & set_legal;
  // Any set request, legal or not, swallows a coincident tick.
  assign cnt       = tick & en & ~set_valid;

  rtc_wrap_counter #(.W(SEC_W), .MAX(SEC_MAX)) u_sec (
    .clk       (clk),
    .rst       (rst),
    .inc       (cnt),
    .load      (load),
    .load_val  (set_time.sec),
    .val       (sec),
    .carry_out (sec_carry)
  );

  rtc_wrap_counter #(.W(MIN_W), .MAX(MIN_MAX)) u_min (
    .clk       (clk),
    .rst       (rst),
    .inc       (sec_carry),
    .load      (load),
    .load_val  (set_time.min),
    .val       (min),
    .carry_out (min_carry)
  );

  rtc_wrap_counter #(.W(HR_W), .MAX(HOURS_PER_DAY-1)) u_hr (
    .clk       (clk),
    .rst       (rst),
    .inc       (min_carry),
    .load      (load),
    .load_val  (set_time.hr),
    .val       (hr),
    .carry_out (hr_carry)
  );

  // A new ss==00 only arises from a seconds carry, so the alarm compares
  // against the hh:mm that this carry is about to produce.
  always_comb begin
    min_nxt = min_carry ? '0 : min + MIN_W'(1);
    hr_nxt  = hr_carry  ? '0 : (min_carry ? hr + HR_W'(1) : hr);
  end

  assign alarm_hit = sec_carry & alarm_en &
                     (hr_nxt == alarm_hr) & (min_nxt == alarm_min);

  always_ff @(posedge clk) begin
    if (rst) begin
      set_ack    <= 1'b0;
      set_err    <= 1'b0;
      day_pulse  <= 1'b0;
      alarm_fire <= 1'b0;
      time_valid <= 1'b0;
    end else begin
      set_ack    <= load;
      set_err    <= set_valid & ~set_legal;
      day_pulse  <= hr_carry;
      alarm_fire <= alarm_hit;
      if (load) time_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Self-checking bench: a seconds-of-day reference model tracks every cycle,
// with a vector table for the set handshake and directed corner sequences.
module tb_rtc_timekeeper;

  localparam int HPD = 24;
  localparam int DAY = HPD * 3600;

  logic       clk = 1'b0;
  logic       rst, sec_clk, en, set_valid, alarm_en;
  logic [4:0] set_hr, alarm_hr, hr;
  logic [5:0] set_min, set_sec, alarm_min, min, sec;
  logic       set_ack, set_err, day_pulse, alarm_fire, time_valid;

  rtc_timekeeper #(.HOURS_PER_DAY(HPD)) dut (
    .clk(clk), .rst(rst), .sec_clk(sec_clk), .en(en),
    .set_valid(set_valid), .set_hr(set_hr), .set_min(set_min), .set_sec(set_sec),
    .set_ack(set_ack), .set_err(set_err),
    .alarm_en(alarm_en), .alarm_hr(alarm_hr), .alarm_min(alarm_min),
    .hr(hr), .min(min), .sec(sec),
    .day_pulse(day_pulse), .alarm_fire(alarm_fire), .time_valid(time_valid)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // reference model: time as seconds since midnight
  int m_t = 0;
  bit m_tv = 0, m_prev = 1, e_ack = 0, e_err = 0, e_day = 0, e_al = 0;

  typedef struct {
    logic sv;
    int   shr, smin, ssec;
    int   ehr, emin, esec;
    logic eack, eerr, etv;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_step();
    bit tk;
    e_ack = 0; e_err = 0; e_day = 0; e_al = 0;
    if (rst) begin
      m_t = 0; m_tv = 0; m_prev = 1;
      return;
    end
    tk = sec_clk && !m_prev;
    m_prev = sec_clk;
    if (set_valid) begin
      if (set_hr < HPD && set_min < 60 && set_sec < 60) begin
        m_t = set_hr * 3600 + set_min * 60 + set_sec;
        m_tv = 1; e_ack = 1;
      end else e_err = 1;
    end else if (tk && en) begin
      m_t = (m_t + 1) % DAY;
      e_day = (m_t == 0);
      e_al = alarm_en && (m_t == alarm_hr * 3600 + alarm_min * 60);
    end
  endtask

  // One clock with the currently driven inputs, then full output compare.
  task automatic cycle(input string tag);
    model_step();
    @(posedge clk); #1;
    chk({tag, ".hr"},  hr,  m_t / 3600);
    chk({tag, ".min"}, min, (m_t / 60) % 60);
    chk({tag, ".sec"}, sec, m_t % 60);
    chk({tag, ".ack"}, set_ack, e_ack);
    chk({tag, ".err"}, set_err, e_err);
    chk({tag, ".day"}, day_pulse, e_day);
    chk({tag, ".alarm"}, alarm_fire, e_al);
    chk({tag, ".tv"},  time_valid, m_tv);
  endtask

  task automatic sec_edge(input string tag);
    sec_clk = 1'b0; cycle(tag);
    sec_clk = 1'b1; cycle(tag);
  endtask

  task automatic do_set(input string tag, input int h, input int m, input int s);
    set_valid = 1'b1; set_hr = 5'(h); set_min = 6'(m); set_sec = 6'(s);
    cycle(tag);
    set_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sec_clk = 1'b1; en = 1'b1; set_valid = 1'b0;
    set_hr = '0; set_min = '0; set_sec = '0;
    alarm_en = 1'b0; alarm_hr = '0; alarm_min = '0;

    tbl[0] = '{1'b1, 31,  0,  0,   0,  0,  3, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 23, 59, 58,  23, 59, 58, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{1'b0,  0,  0,  0,  23, 59, 58, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 10, 60,  0,  23, 59, 58, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{1'b1, 24,  0,  0,  23, 59, 58, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{1'b1, 12, 34, 56,  12, 34, 56, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{1'b1,  5, 59, 60,  12, 34, 56, 1'b0, 1'b1, 1'b1};
    tbl[7] = '{1'b0,  0,  0,  0,  12, 34, 56, 1'b0, 1'b0, 1'b1};
    tbl[8] = '{1'b1, 23, 59, 58,  23, 59, 58, 1'b1, 1'b0, 1'b1};

    // reset with sec_clk high; release must not count
    cycle("rst0"); cycle("rst1");
    rst = 1'b0;
    cycle("release");
    chk("no_tick_at_release", sec, 0);
    for (int i = 0; i < 3; i++) sec_edge("count3");
    chk("count3.sec", sec, 3);
    chk("count3.tv", time_valid, 0);

    // set handshake table, sec_clk held low
    sec_clk = 1'b0;
    for (int i = 0; i < 9; i++) begin
      set_valid = tbl[i].sv;
      set_hr = 5'(tbl[i].shr); set_min = 6'(tbl[i].smin); set_sec = 6'(tbl[i].ssec);
      cycle($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.hr", i),  hr,  tbl[i].ehr);
      chk($sformatf("tbl%0d.min", i), min, tbl[i].emin);
      chk($sformatf("tbl%0d.sec", i), sec, tbl[i].esec);
      chk($sformatf("tbl%0d.ack", i), set_ack, tbl[i].eack);
      chk($sformatf("tbl%0d.err", i), set_err, tbl[i].eerr);
      chk($sformatf("tbl%0d.tv", i),  time_valid, tbl[i].etv);
    end
    set_valid = 1'b0;

    // day wrap
    sec_edge("wrap1");
    chk("wrap1.sec", sec, 59);
    chk("wrap1.day", day_pulse, 0);
    sec_edge("wrap2");
    chk("wrap2.hms", {hr, min, sec}, 0);
    chk("wrap2.day", day_pulse, 1);
    cycle("wrap3");
    chk("wrap3.day", day_pulse, 0);

    // set beats a coincident tick
    sec_clk = 1'b0;
    do_set("pre_race", 7, 15, 29);
    sec_clk = 1'b1;
    do_set("race", 7, 15, 30);
    chk("race.sec", sec, 30);
    cycle("race_hold");
    chk("race_hold.sec", sec, 30);

    // alarm fires from a tick, not from a load
    alarm_en = 1'b1; alarm_hr = 5'd7; alarm_min = 6'd16;
    do_set("al_set", 7, 15, 59);
    sec_edge("al_tick");
    chk("al_tick.fire", alarm_fire, 1);
    chk("al_tick.min", min, 16);
    cycle("al_after");
    chk("al_after.fire", alarm_fire, 0);
    do_set("al_load", 7, 16, 0);
    chk("al_load.fire", alarm_fire, 0);
    alarm_en = 1'b0;

    // edges while disabled are discarded, not deferred
    en = 1'b0;
    for (int i = 0; i < 5; i++) sec_edge("en_off");
    chk("en_off.sec", sec, 0);
    en = 1'b1;
    sec_edge("en_on");
    chk("en_on.sec", sec, 1);
    cycle("en_on2");
    chk("en_on2.sec", sec, 1);

    // reset mid-operation drops a pending set
    rst = 1'b1; set_valid = 1'b1; set_hr = 5'd3; set_min = 6'd4; set_sec = 6'd5;
    sec_clk = 1'b0;
    cycle("mid_rst");
    chk("mid_rst.hms", {hr, min, sec}, 0);
    chk("mid_rst.tv", time_valid, 0);
    chk("mid_rst.ack", set_ack, 0);
    rst = 1'b0; set_valid = 1'b0;
    cycle("post_rst");

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 1) == 0) sec_clk = ~sec_clk;
      set_valid = ($urandom_range(0, 15) == 0);
      set_hr = 5'($urandom_range(0, 25));
      set_min = ($urandom_range(0, 1) == 0) ? 6'd59 : 6'($urandom_range(0, 63));
      set_sec = 6'($urandom_range(50, 63));
      if ($urandom_range(0, 7) == 0) begin
        alarm_en = ($urandom_range(0, 3) != 0);
        alarm_hr = 5'(((m_t + 60) % DAY) / 3600);
        alarm_min = 6'((((m_t + 60) % DAY) / 60) % 60);
      end
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end

endmodule

// File: doc/rtc_timekeeper.md
Name: rtc_timekeeper

Overview:
Consumer end of the seconds-tick interface. Takes the divided square wave from the tick generator and counts hours/minutes/seconds. Provides a validated set handshake and an hh:mm alarm. Sits between the tick generator and display/bus logic.

Parameters:
HOURS_PER_DAY, 24, hour modulus; legal range 2..32; hour counter wraps HOURS_PER_DAY-1 -> 0.

Ports:
clk  input  1  system clock, same domain as the tick generator
rst  input  1  synchronous, active-high reset
sec_clk  input  1  seconds square wave from the tick generator, registered in the clk domain; each rising edge is one second
en  input  1  1 = count seconds; 0 = hold time; edges seen while 0 are discarded
set_valid  input  1  request to load time
set_hr  input  5  hour to load
set_min  input  6  minute to load
set_sec  input  6  second to load
set_ack  output  1  one-cycle pulse: load accepted
set_err  output  1  one-cycle pulse: load rejected (out of range)
alarm_en  input  1  alarm enable
alarm_hr  input  5  alarm hour
alarm_min  input  6  alarm minute
hr  output  5  current hour, registered
min  output  6  current minute, registered
sec  output  6  current second, registered
day_pulse  output  1  one-cycle pulse on hour wrap to 0
alarm_fire  output  1  one-cycle pulse on alarm match
time_valid  output  1  0 after reset; 1 after the first accepted set

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: hr=min=sec=0, set_ack=set_err=day_pulse=alarm_fire=0, time_valid=0. Edge register sec_clk_q=1, so a high sec_clk at reset release gives no spurious tick.
- Edge detect: tick = sec_clk & ~sec_clk_q. sec_clk_q <= sec_clk every cycle.
- No synchronizer: sec_clk is already registered in the clk domain.
- Latency: counters update on the first clk edge where sec_clk is sampled high after being low. There is no added pipeline delay.
- Count on tick & en:
  - sec increments.
  - sec==59 -> sec=0, min increments.
  - min==59 with carry -> min=0, hr increments.
  - hr==HOURS_PER_DAY-1 with carry -> hr=0, and day_pulse=1 in the same update cycle.
- tick & !en: edge consumed and no change; it is not deferred until en returns.
- Set, evaluated when set_valid=1:
  - Legal: set_hr<HOURS_PER_DAY, set_min<=59, set_sec<=59.
  - Legal -> load all three next edge; set_ack=1 that cycle; time_valid=1 (sticky until rst).
  - Illegal -> time unchanged; set_err=1 that cycle.
  - set_valid held high re-evaluates every cycle, giving one ack/err per cycle. The requester must drop set_valid after the ack/err.
- Set concurrent with tick: the set wins and the tick is dropped. An illegal set also drops the tick.
- Alarm:
  - alarm_fire=1 for one cycle when a tick-driven update produces hr==alarm_hr, min==alarm_min, sec==0, and alarm_en=1.
  - Loading a matching time via set never fires.
  - alarm_en is sampled in the update cycle.
- Pulse outputs are registered and are 0 in every cycle without their event.
- rst mid-operation: all state returns to reset values next edge; a pending set is dropped with no ack/err.
- Arithmetic: each field is an unsigned modulo counter. Field values are never out of range: a legal reset, a validated load, or a wrap is the only way to change them.

Decomposition:
- Package rtc_pkg:
  - Constants SEC_W=6, MIN_W=6, HR_W=5, SEC_MAX=59, MIN_MAX=59.
  - Typedef rtc_time_t as a packed struct {hr, min, sec}.
  - Shared with future display and bus blocks.
- One sub-module rtc_wrap_counter, parameterized by width and max:
  - Inputs: clk, rst, inc, load, load_val.
  - Outputs: val, carry_out.
  - carry_out = inc & (val==max).
  - Instantiated three times in a carry chain.

Test Plan:
- Reset with sec_clk=1, then 3 rising edges of sec_clk -> no tick at reset release; sec=3, min=0, hr=0, time_valid=0.
- Set 23:59:58 (legal) -> set_ack one cycle, time_valid=1. Then 2 edges -> 00:00:00, with day_pulse high for exactly the cycle of the 23:59:59->00:00:00 update.
- Set 10:60:00 -> set_err one cycle; time unchanged; time_valid unchanged; no set_ack.
- set_valid (07:15:30) in the same cycle as a sec_clk rise from 07:15:29 state -> result 07:15:30, not 07:15:31; the tick is dropped.
- alarm 07:16 with alarm_en=1, set 07:15:59, 1 edge -> alarm_fire one cycle. Then set 07:16:00 directly -> no alarm_fire.
- en=0 across 5 edges, then en=1 plus 1 edge -> time advances by exactly 1 second. Then assert rst mid-count -> all outputs 0 next edge.
